ocr_frame_sequencer: RTL and testbench

- Parametrised successor of the byte-level OCR control path.
- Consumes command/data bytes from the SPI peripheral through a valid/taken handshake and writes image bytes into the image buffer at explicit addresses.
- Launches BNN inference automatically or on command, and latches the classification result.
- Adds an inactivity watchdog, illegal-command detection and a frame counter.

---
 rtl/ocr_seq_pkg.sv | 30 +++
 rtl/seq_watchdog.sv | 38 +++
 rtl/ocr_frame_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ocr_frame_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocr_seq_pkg.sv
// Shared types and constants for the OCR frame sequencer.
package ocr_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoadRx,
      StLoadWr,
      StInferStart,
      StInferWait,
      StClear,
      StError
   } seq_state_e;

   // Command opcodes, only decoded in IDLE (CLEAR also in ERROR)
   localparam logic [7:0] OpLoad  = 8'h01;
   localparam logic [7:0] OpInfer = 8'h02;
   localparam logic [7:0] OpClear = 8'h03;

   // Externally visible status codes
   localparam logic [3:0] StatusIdle   = 4'h0;
   localparam logic [3:0] StatusLoad   = 4'h1;
   localparam logic [3:0] StatusInfer  = 4'h2;
   localparam logic [3:0] StatusResult = 4'h3;
   localparam logic [3:0] StatusClear  = 4'h4;
   localparam logic [3:0] StatusError  = 4'hE;

   // Result value meaning "no valid class"
   localparam logic [3:0] ResultBlank = 4'hF;

endpackage

// File: rtl/seq_watchdog.sv
// Inactivity watchdog: reloads while disabled or kicked, counts down otherwise and flags
// expiry in the cycle the count reaches zero.
module seq_watchdog #(
   parameter int unsigned Cycles = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic kick_i,
   output logic expire_o
);

   localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
   localparam logic [CntW-1:0] Reload = CntW'(Cycles - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Next count and expiry; a kick in the expiry cycle suppresses the expiry
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || kick_i) begin
         cnt_d = Reload;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
      expire_o = en_i && !kick_i && (cnt_q == '0);
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= Reload;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ocr_frame_sequencer.sv
// OCR frame sequencer: decodes SPI command bytes, streams image bytes into the buffer,
// launches BNN inference and latches the classification result.
module ocr_frame_sequencer
   import ocr_seq_pkg::*;
#(
   parameter int unsigned IMG_BYTES      = 113,
   parameter int unsigned ADDR_W         = 7,
   parameter int unsigned RESULT_W       = 4,
   parameter int unsigned NUM_CLASSES    = 10,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter bit          AUTO_INFER     = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data_i,
   input  logic                rx_valid_i,
   output logic                rx_taken_o,
   output logic                rx_enable_o,
   output logic                buf_wr_req_o,
   input  logic                buf_wr_ready_i,
   output logic [7:0]          buf_wr_data_o,
   output logic [ADDR_W-1:0]   buf_wr_addr_o,
   output logic                buf_clear_o,
   input  logic                buf_full_i,
   output logic                bnn_start_o,
   input  logic                bnn_done_i,
   input  logic [RESULT_W-1:0] bnn_result_i,
   output logic [RESULT_W-1:0] result_out_o,
   output logic                result_valid_o,
   output logic [3:0]          status_code_o,
   output logic                err_flag_o,
   output logic [7:0]          frame_count_o
);

   localparam logic [RESULT_W-1:0] Blank    = RESULT_W'(ResultBlank);
   localparam logic [ADDR_W-1:0]   LastAddr = ADDR_W'(IMG_BYTES - 1);

   seq_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_req_q, wr_req_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic                rx_taken_q, rx_taken_d;
   logic                buf_clear_q, buf_clear_d;
   logic [RESULT_W-1:0] result_q, result_d;
   logic                result_valid_q, result_valid_d;
   logic                err_q, err_d;
   logic [7:0]          frame_cnt_q, frame_cnt_d;
   logic                handshake, wd_en, wd_expire, load_cmd;

   seq_watchdog #(
      .Cycles (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .en_i     (wd_en),
      .kick_i   (rx_taken_q | handshake),
      .expire_o (wd_expire)
   );

   // Byte intake, write handshake, watchdog enable and status decode
   always_comb begin
      rx_enable_o = (state_q == StIdle) || (state_q == StLoadRx) || (state_q == StError);
      // The taken pulse itself blocks a second consume of the same held byte
      rx_taken_d  = rx_valid_i && rx_enable_o && !rx_taken_q;
      handshake   = wr_req_q && buf_wr_ready_i;
      wd_en       = (state_q == StLoadRx) || (state_q == StLoadWr) || (state_q == StInferWait);
      unique case (state_q)
         StIdle:                    status_code_o = result_valid_q ? StatusResult : StatusIdle;
         StLoadRx, StLoadWr:        status_code_o = StatusLoad;
         StInferStart, StInferWait: status_code_o = StatusInfer;
         StClear:                   status_code_o = StatusClear;
         default:                   status_code_o = StatusError;
      endcase
   end

   // Sequencer next-state; byte consume and write handshake take priority over timeout
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      wr_req_d       = wr_req_q;
      wr_data_d      = wr_data_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      err_d          = err_q;
      frame_cnt_d    = frame_cnt_q;
      load_cmd       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rx_taken_q) begin
               case (rx_data_i)
                  OpLoad: begin
                     load_cmd       = 1'b1;
                     addr_d         = '0;
                     result_valid_d = 1'b0;
                     state_d        = StLoadRx;
                  end
                  OpInfer: state_d = buf_full_i ? StInferStart : StError;
                  OpClear: state_d = StClear;
                  default: err_d   = 1'b1;
               endcase
            end
         end
         StLoadRx: begin
            if (rx_taken_q) begin
               wr_data_d = rx_data_i;
               wr_req_d  = 1'b1;
               state_d   = StLoadWr;
            end else if (wd_expire) begin
               state_d = StError;
            end
         end
         StLoadWr: begin
            if (handshake) begin
               wr_req_d = 1'b0;
               addr_d   = addr_q + 1'b1;
               if (addr_q == LastAddr) begin
                  state_d = AUTO_INFER ? StInferStart : StIdle;
               end else begin
                  state_d = StLoadRx;
               end
            end else if (wd_expire) begin
               wr_req_d = 1'b0;
               state_d  = StError;
            end
         end
         StInferStart: state_d = StInferWait;
         StInferWait: begin
            if (bnn_done_i) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               if (32'(bnn_result_i) < NUM_CLASSES) begin
                  result_d       = bnn_result_i;
                  result_valid_d = 1'b1;
               end else begin
                  result_d       = Blank;
                  result_valid_d = 1'b0;
                  err_d          = 1'b1;
               end
               state_d = StIdle;
            end else if (wd_expire) begin
               state_d = StError;
            end
         end
         StClear: begin
            result_d       = Blank;
            result_valid_d = 1'b0;
            err_d          = 1'b0;
            state_d        = StIdle;
         end
         StError: begin
            if (rx_taken_q && (rx_data_i == OpClear)) begin
               state_d = StClear;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d == StError) begin
         err_d = 1'b1;
      end
      buf_clear_d = load_cmd || (state_d == StClear);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         addr_q         <= '0;
         wr_req_q       <= 1'b0;
         wr_data_q      <= '0;
         rx_taken_q     <= 1'b0;
         buf_clear_q    <= 1'b0;
         result_q       <= Blank;
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;
         frame_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         wr_req_q       <= wr_req_d;
         wr_data_q      <= wr_data_d;
         rx_taken_q     <= rx_taken_d;
         buf_clear_q    <= buf_clear_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         err_q          <= err_d;
         frame_cnt_q    <= frame_cnt_d;
      end
   end

   assign rx_taken_o     = rx_taken_q;
   assign buf_wr_req_o   = wr_req_q;
   assign buf_wr_data_o  = wr_data_q;
   assign buf_wr_addr_o  = addr_q;
   assign buf_clear_o    = buf_clear_q;
   assign bnn_start_o    = (state_q == StInferStart);
   assign result_out_o   = result_q;
   assign result_valid_o = result_valid_q;
   assign err_flag_o     = err_q;
   assign frame_count_o  = frame_cnt_q;

endmodule

// File: tb/tb_ocr_frame_sequencer.sv
// Scoreboard bench for ocr_frame_sequencer: stimulus pushes expected buffer writes and
// results into queues, a negedge monitor pops and compares them as the DUT produces them.
module tb_ocr_frame_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       rx_taken, rx_enable, buf_wr_req, buf_clear, bnn_start;
   logic       buf_wr_ready = 1'b1;
   logic [7:0] buf_wr_data;
   logic [6:0] buf_wr_addr;
   logic       buf_full = 1'b0;
   logic       bnn_done = 1'b0;
   logic [3:0] bnn_result = '0;
   logic [3:0] result_out, status_code;
   logic       result_valid, err_flag;
   logic [7:0] frame_count;

   ocr_frame_sequencer #(
      .IMG_BYTES      (113),
      .ADDR_W         (7),
      .RESULT_W       (4),
      .NUM_CLASSES    (10),
      .TIMEOUT_CYCLES (100),
      .AUTO_INFER     (1'b1)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_data_i      (rx_data),
      .rx_valid_i     (rx_valid),
      .rx_taken_o     (rx_taken),
      .rx_enable_o    (rx_enable),
      .buf_wr_req_o   (buf_wr_req),
      .buf_wr_ready_i (buf_wr_ready),
      .buf_wr_data_o  (buf_wr_data),
      .buf_wr_addr_o  (buf_wr_addr),
      .buf_clear_o    (buf_clear),
      .buf_full_i     (buf_full),
      .bnn_start_o    (bnn_start),
      .bnn_done_i     (bnn_done),
      .bnn_result_i   (bnn_result),
      .result_out_o   (result_out),
      .result_valid_o (result_valid),
      .status_code_o  (status_code),
      .err_flag_o     (err_flag),
      .frame_count_o  (frame_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] out;
      logic       valid;
      logic [7:0] fc;
      logic       err;
   } res_t;

   logic [14:0] wr_q[$];
   res_t        res_q[$];
   int          n_chk = 0, n_fail = 0;
   int          cyc = 0, starts = 0, last_hs_cyc = 0, bp_wait = 0;
   bit          bp_en = 1'b0, held = 1'b0;
   logic [6:0]  h_addr;
   logic [7:0]  h_data, prev_fc;
   logic [3:0]  exp_out = 4'hF;
   logic        exp_valid = 1'b0, exp_err = 1'b0;
   logic [7:0]  exp_fc = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Buffer model: ready always high, or low for 5 cycles per request in backpressure mode
   always @(posedge clk) begin
      if (!bp_en) begin
         buf_wr_ready <= 1'b1;
         bp_wait      <= 0;
      end else if (buf_wr_req && buf_wr_ready) begin
         buf_wr_ready <= 1'b0;
         bp_wait      <= 0;
      end else if (buf_wr_req) begin
         if (bp_wait == 4) buf_wr_ready <= 1'b1;
         bp_wait <= bp_wait + 1;
      end else begin
         buf_wr_ready <= 1'b0;
      end
   end

   // Monitor: writes and results are popped from the scoreboard as they appear
   always @(negedge clk) begin
      if (rst) begin
         held    = 1'b0;
         prev_fc = frame_count;
      end else begin
         if (bnn_start) starts++;
         if (buf_wr_req) begin
            check("rx_enable during write", rx_enable, 0);
            if (held) begin
               check("wr addr stable", buf_wr_addr, h_addr);
               check("wr data stable", buf_wr_data, h_data);
            end
            if (buf_wr_ready) begin
               last_hs_cyc = cyc;
               held        = 1'b0;
               n_chk++;
               if (wr_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected write: addr 0x%0h data 0x%0h, none expected",
                           buf_wr_addr, buf_wr_data);
               end else begin
                  logic [14:0] e;
                  e = wr_q.pop_front();
                  check("wr addr", buf_wr_addr, e[14:8]);
                  check("wr data", buf_wr_data, e[7:0]);
               end
            end else begin
               held   = 1'b1;
               h_addr = buf_wr_addr;
               h_data = buf_wr_data;
            end
         end else begin
            held = 1'b0;
         end
         if (frame_count != prev_fc) begin
            n_chk++;
            if (res_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected result: frame_count 0x%0h, none expected", frame_count);
            end else begin
               res_t e;
               e = res_q.pop_front();
               check("result_out", result_out, e.out);
               check("result_valid", result_valid, e.valid);
               check("frame_count", frame_count, e.fc);
               check("err_flag after result", err_flag, e.err);
            end
         end
         prev_fc = frame_count;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      bit got = 1'b0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (rx_taken) got = 1'b1;
      end
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL rx_taken timeout: byte 0x%0h never taken", b);
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic wait_status(input logic [3:0] s, input string name);
      for (int i = 0; i < 50 && status_code != s; i++) @(negedge clk);
      check(name, status_code, s);
   endtask

   task automatic push_result(input logic [3:0] r);
      exp_fc = exp_fc + 8'd1;
      if (r < 4'd10) begin
         exp_out   = r;
         exp_valid = 1'b1;
      end else begin
         exp_out   = 4'hF;
         exp_valid = 1'b0;
         exp_err   = 1'b1;
      end
      res_q.push_back({exp_out, exp_valid, exp_fc, exp_err});
   endtask

   task automatic run_infer(input logic [3:0] r);
      wait_status(4'h2, "status infer");
      @(posedge clk);
      #1 bnn_done = 1'b1;
      bnn_result = r;
      @(posedge clk);
      #1 bnn_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_state();
      check("rst status", status_code, 0);
      check("rst wr_req", buf_wr_req, 0);
      check("rst result_out", result_out, 4'hF);
      check("rst result_valid", result_valid, 0);
      check("rst err_flag", err_flag, 0);
      check("rst frame_count", frame_count, 0);
      check("rst bnn_start", bnn_start, 0);
      check("rst rx_taken", rx_taken, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int s0, h;
      logic [7:0] d;
      // Reset state
      repeat (2) @(negedge clk);
      check_reset_state();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle rx_enable", rx_enable, 1);

      // Full frame with automatic inference
      send_byte(8'h01);
      for (int i = 0; i < 113; i++) begin
         d = 8'(i * 7 + 3);
         wr_q.push_back({7'(i), d});
         send_byte(d);
      end
      s0 = starts;
      push_result(4'd7);
      run_infer(4'd7);
      check("one bnn_start", starts - s0, 1);
      check("status result", status_code, 4'h3);
      check("frame writes drained", wr_q.size(), 0);

      // Stray bnn_done in IDLE must be ignored
      @(posedge clk);
      #1 bnn_done = 1'b1;
      bnn_result = 4'd2;
      @(posedge clk);
      #1 bnn_done = 1'b0;
      repeat (2) @(negedge clk);
      check("stray done result", result_out, 4'd7);

      // Backpressure on the first 10 bytes, then 40 more bytes, then reset mid-load
      bp_en = 1'b1;
      send_byte(8'h01);
      check("load clears valid", result_valid, 0);
      check("load status", status_code, 4'h1);
      for (int i = 0; i < 50; i++) begin
         if (i == 10) bp_en = 1'b0;
         d = 8'(8'hA0 ^ i);
         wr_q.push_back({7'(i), d});
         send_byte(d);
      end
      repeat (3) @(negedge clk);
      check("bp writes drained", wr_q.size(), 0);
      #2 rst = 1'b1;
      exp_fc = '0; exp_out = 4'hF; exp_valid = 1'b0; exp_err = 1'b0;
      @(negedge clk);
      check_reset_state();
      @(negedge clk);
      rst = 1'b0;
      s0 = starts;
      send_byte(8'h10);
      send_byte(8'h20);
      repeat (3) @(negedge clk);
      check("post-rst no start", starts - s0, 0);
      check("post-rst status", status_code, 0);
      check("unknown after rst err", err_flag, 1);
      send_byte(8'h03);
      wait_status(4'h0, "clear to idle");
      check("clear err", err_flag, 0);

      // Manual infer without and with a full buffer
      buf_full = 1'b0;
      send_byte(8'h02);
      wait_status(4'hE, "infer empty error");
      check("infer empty err", err_flag, 1);
      send_byte(8'h10);
      repeat (2) @(negedge clk);
      check("error drops byte", status_code, 4'hE);
      send_byte(8'h03);
      wait_status(4'h0, "error cleared");
      check("error cleared err", err_flag, 0);
      buf_full = 1'b1;
      s0 = starts;
      push_result(4'd12);
      send_byte(8'h02);
      run_infer(4'd12);
      check("manual bnn_start", starts - s0, 1);
      check("invalid result blank", result_out, 4'hF);
      check("invalid result err", err_flag, 1);

      // Watchdog: byte in the expiry cycle keeps LOAD, then silence ends in ERROR
      send_byte(8'h01);
      for (int i = 0; i < 40; i++) begin
         wr_q.push_back({7'(i), 8'(i + 1)});
         send_byte(8'(i + 1));
      end
      repeat (2) @(negedge clk);
      h = last_hs_cyc;
      do begin
         @(posedge clk);
         #1;
      end while (cyc < h + 99);
      check("no early timeout", status_code, 4'h1);
      wr_q.push_back({7'd40, 8'h5C});
      send_byte(8'h5C);
      check("byte beats timeout", status_code, 4'h1);
      repeat (2) @(negedge clk);
      h = last_hs_cyc;
      for (int i = 0; i < 300 && status_code == 4'h1; i++) @(negedge clk);
      check("timeout latency", cyc - h, 101);
      check("timeout status", status_code, 4'hE);
      send_byte(8'h03);
      wait_status(4'h0, "timeout cleared");

      // Unknown opcode
      send_byte(8'h5A);
      repeat (2) @(negedge clk);
      check("5A err", err_flag, 1);
      check("5A status", status_code, 0);
      exp_err = 1'b1;

      // Frame counter wraps after 256 frames since reset
      for (int k = 0; k < 255; k++) begin
         push_result(4'(k % 10));
         send_byte(8'h02);
         run_infer(4'(k % 10));
      end
      check("frame_count wrap", frame_count, 0);
      check("writes drained", wr_q.size(), 0);
      check("results drained", res_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
